seg7_scan_mux: RTL and testbench

- Parametrised time-multiplexed seven-segment driver for the lab board's hz100 domain; drives DIGITS common-enable digits from one shared segment bus.
- Hex-decodes a packed nibble value and scans the digits round-robin.
- Double-buffers loads so the displayed value only changes on a scan-frame boundary (no tearing); supports leading-zero blanking and per-digit decimal points.
- Sits between datapath/ALU results and the ss*/segment outputs in system_top.

---
 rtl/seg7_scan_mux_if.sv | 27 ++
 rtl/seg7_scan_mux.sv | 112 +++++++++++
 tb/tb_seg7_scan_mux.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Interface bundle for seg7_scan_mux: load handshake, display data and scan outputs.
// Optional SEG7_BLINK_EN adds the live blink_mask signal.
interface seg7_scan_mux_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lzb;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]     blink_mask;
`endif
  logic [7:0]            seg;
  logic [DIGITS-1:0]     digit_en;
  logic                  pending;
  logic                  done;

`ifdef SEG7_BLINK_EN
  modport master (output load, value, dp_in, lzb, blink_mask,
                  input  seg, digit_en, pending, done);
  modport slave  (input  load, value, dp_in, lzb, blink_mask,
                  output seg, digit_en, pending, done);
`else
  modport master (output load, value, dp_in, lzb,
                  input  seg, digit_en, pending, done);
  modport slave  (input  load, value, dp_in, lzb,
                  output seg, digit_en, pending, done);
`endif
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering,
// leading-zero blanking and decimal points. Define SEG7_BLINK_EN for per-digit blinking.
module seg7_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 50
) (
  input  logic           hz100,
  input  logic           reset,
  seg7_scan_mux_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val, disp_val;
  logic [DIGITS-1:0]   shadow_dp, disp_dp;
  logic                frame_wrap, blank, blink_off;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign frame_wrap = (div == LAST_DIV) && (idx == LAST_IDX);
  assign nib        = disp_val[4*idx +: 4];

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    if (bus.lzb && (idx != '0)) begin
      blank = 1'b1;
      for (int k = 0; k < DIGITS; k++)
        if ((k >= int'(idx)) && (disp_val[4*k +: 4] != 4'h0)) blank = 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_off = ~blink_on & bus.blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      div          <= '0;
      idx          <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
      bus.pending  <= 1'b0;
      bus.done     <= 1'b0;
      bus.seg      <= 8'h00;
      bus.digit_en <= '0;
    end else begin
      bus.done <= 1'b0;
      if (div == LAST_DIV) begin
        div <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end

      // A load landing on the wrap cycle bypasses the shadow and commits directly.
      if (frame_wrap) begin
        if (bus.load) begin
          disp_val    <= bus.value;
          disp_dp     <= bus.dp_in;
          bus.pending <= 1'b0;
          bus.done    <= 1'b1;
        end else if (bus.pending) begin
          disp_val    <= shadow_val;
          disp_dp     <= shadow_dp;
          bus.pending <= 1'b0;
          bus.done    <= 1'b1;
        end
      end else if (bus.load) begin
        shadow_val  <= bus.value;
        shadow_dp   <= bus.dp_in;
        bus.pending <= 1'b1;
      end

      bus.digit_en <= DIGITS'(1) << idx;
      bus.seg      <= blink_off ? 8'h00 : {disp_dp[idx], blank ? 7'h00 : hex7(nib)};
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: frame-level reference model, vector table,
// directed handshake/reset sequences and randomized traffic.
module tb_seg7_scan_mux;
  localparam int D         = 4;
  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 4;
  localparam int FRAME     = D * SCAN_DIV;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic hz100, reset;
  seg7_scan_mux_if #(.DIGITS(D)) bus ();

  seg7_scan_mux #(.DIGITS(D), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .hz100(hz100), .reset(reset), .bus(bus));

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  int n_tests = 0, n_fail = 0;
  int tick;
  logic [4*D-1:0] m_val, s_val;
  logic [D-1:0]   m_dp, s_dp;
  bit             m_pend;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    tick = 0; m_val = '0; s_val = '0; m_dp = '0; s_dp = '0; m_pend = 0;
  endtask

  task automatic do_reset();
    bus.load = 0;
    @(negedge hz100); reset = 1;
    @(negedge hz100); @(negedge hz100); reset = 0;
    model_reset();
  endtask

  // Predicts the outputs produced by the next edge from the frame position, then checks them.
  task automatic step();
    int i; bit wrap, exp_done, blank; logic [3:0] nib; logic [7:0] es;
    i     = (tick / SCAN_DIV) % D;
    wrap  = (tick % FRAME) == FRAME - 1;
    nib   = 4'((m_val >> (4 * i)) & 16'hF);
    blank = bus.lzb && (i > 0) && ((m_val >> (4 * i)) == 0);
    es    = {m_dp[i], blank ? 7'h00 : HEX[nib]};
`ifdef SEG7_BLINK_EN
    if ((((tick / BLINK_DIV) % 2) == 1) && bus.blink_mask[i]) es = 8'h00;
`endif
    exp_done = 0;
    if (wrap && (bus.load || m_pend)) begin
      m_val = bus.load ? bus.value : s_val;
      m_dp  = bus.load ? bus.dp_in : s_dp;
      m_pend = 0; exp_done = 1;
    end else if (!wrap && bus.load) begin
      s_val = bus.value; s_dp = bus.dp_in; m_pend = 1;
    end
    @(posedge hz100); #1; tick++;
    chk("seg",      32'(bus.seg), 32'(es));
    chk("digit_en", 32'(bus.digit_en), 32'(1 << i));
    chk("pending",  32'(bus.pending), 32'(m_pend));
    chk("done",     32'(bus.done), 32'(exp_done));
  endtask

  task automatic load_step(input logic [15:0] v, input logic [3:0] dp);
    bus.value = v; bus.dp_in = dp; bus.load = 1;
    step();
    bus.load = 0;
  endtask

  task automatic align(input int phase);
    while ((tick % FRAME) != phase) step();
  endtask

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [7];
  logic [7:0] got [D];
  bit seen_done, seen_one, seen_two;
  int dcount, blank_cyc, lit_cyc;
  logic [15:0] exp_en [10];

  initial begin
    reset = 1; bus.load = 0; bus.value = '0; bus.dp_in = '0; bus.lzb = 0;
`ifdef SEG7_BLINK_EN
    bus.blink_mask = '0;
`endif
    vecs[0] = '{16'h1A3F, 4'b0100, 1'b0, 32'h06F74F71};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 32'h0000006D};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'h0000003F};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, 32'h3F3F3F3F};
    vecs[4] = '{16'h00C0, 4'b1000, 1'b1, 32'h8000393F};
    vecs[5] = '{16'h2222, 4'b0000, 1'b0, 32'h5B5B5B5B};
    vecs[6] = '{16'h0B0E, 4'b0001, 1'b1, 32'h007C3FF9};
    exp_en = '{16'h0, 16'h1, 16'h1, 16'h2, 16'h2, 16'h4, 16'h4, 16'h8, 16'h8, 16'h1};

    // Reset state and scan order.
    do_reset();
    chk("rst_seg", 32'(bus.seg), 32'h0);
    chk("rst_en",  32'(bus.digit_en), 32'h0);
    chk("rst_pend", 32'(bus.pending), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    for (int c = 1; c < 10; c++) begin
      step();
      chk("scan_en", 32'(bus.digit_en), 32'(exp_en[c]));
      chk("scan_seg", 32'(bus.seg), 32'h3F);
    end

    // Vector table: load mid-frame, wait for commit, capture one frame per digit.
    foreach (vecs[v]) begin
      bus.lzb = vecs[v].lzb;
      align(2);
      load_step(vecs[v].value, vecs[v].dp);
      chk("pend_after_load", 32'(bus.pending), 32'h1);
      seen_done = 0;
      for (int c = 0; c < 3 * FRAME && !seen_done; c++) begin
        step();
        seen_done = bus.done;
      end
      chk("commit_timeout", 32'(seen_done), 32'h1);
      for (int c = 0; c < FRAME + 1; c++) begin
        step();
        for (int k = 0; k < D; k++) if (bus.digit_en == D'(1 << k)) got[k] = bus.seg;
      end
      for (int k = 0; k < D; k++) chk("vec_seg", 32'(got[k]), 32'(vecs[v].segs[8*k +: 8]));
    end

    // Two loads in one frame: only the latest is ever shown, one done.
    bus.lzb = 0;
    align(0);
    load_step(16'h1111, 4'h0);
    step();
    load_step(16'h2222, 4'h0);
    dcount = 0; seen_one = 0; seen_two = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      step();
      dcount += int'(bus.done);
      if (bus.seg == 8'h06) seen_one = 1;
      if (bus.seg == 8'h5B) seen_two = 1;
    end
    chk("dbl_done_count", 32'(dcount), 32'd1);
    chk("dbl_no_1111", 32'(seen_one), 32'h0);
    chk("dbl_shows_2222", 32'(seen_two), 32'h1);

    // Load exactly on the frame-wrap cycle bypasses the shadow.
    align(FRAME - 1);
    load_step(16'h00C0, 4'h0);
    chk("wrap_pending", 32'(bus.pending), 32'h0);
    chk("wrap_done", 32'(bus.done), 32'h1);
    repeat (FRAME + 2) step();

`ifdef SEG7_BLINK_EN
    bus.blink_mask = 4'b0001;
    blank_cyc = 0; lit_cyc = 0;
    repeat (32) begin
      step();
      if (bus.digit_en == 4'b0001) begin
        if (bus.seg == 8'h00) blank_cyc++; else lit_cyc++;
      end
    end
    chk("blink_off_seen", 32'(blank_cyc > 0), 32'h1);
    chk("blink_on_seen",  32'(lit_cyc > 0), 32'h1);
    bus.blink_mask = '0;
`endif

    // Async reset mid-frame with a pending load: discarded, no done.
    align(2);
    load_step(16'h4321, 4'hF);
    chk("pre_rst_pend", 32'(bus.pending), 32'h1);
    #2; reset = 1; #1;
    chk("arst_seg", 32'(bus.seg), 32'h0);
    chk("arst_en", 32'(bus.digit_en), 32'h0);
    chk("arst_pend", 32'(bus.pending), 32'h0);
    chk("arst_done", 32'(bus.done), 32'h0);
    @(negedge hz100); @(negedge hz100); reset = 0;
    model_reset();
    dcount = 0;
    repeat (3 * FRAME) begin
      step();
      dcount += int'(bus.done);
    end
    chk("arst_no_done", 32'(dcount), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.load  = ($urandom_range(5) == 0);
      bus.value = 16'($urandom);
      bus.dp_in = 4'($urandom);
      if ($urandom_range(19) == 0) bus.lzb = ~bus.lzb;
`ifdef SEG7_BLINK_EN
      if ($urandom_range(31) == 0) bus.blink_mask = 4'($urandom);
`endif
      step();
    end
    bus.load = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
